cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 8-bit CLA.
- Operand width is built from GROUP-bit lookahead groups. The carry chain is split into STAGES register stages.
- A valid/ready handshake with backpressure lets it sit in any streaming datapath. Throughput is one operation per clock.

---
 rtl/cla_pipe_adder.sv | 155 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves one WIDTH/STAGES slice; unresolved operand bits ride along skewed.
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int W_S  = WIDTH / STAGES;
  localparam int NG_S = W_S / GROUP;

  if (WIDTH % GROUP != 0) begin : g_bad_group
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end
  if (STAGES < 1 || STAGES > WIDTH / GROUP) begin : g_bad_stages
    $error("cla_pipe_adder: STAGES must be in 1..WIDTH/GROUP");
  end
  if ((WIDTH / GROUP) % STAGES != 0) begin : g_bad_split
    $error("cla_pipe_adder: WIDTH/GROUP must be divisible by STAGES");
  end

  // Slice adder: group generate/propagate give group carries, bits ripple only inside a group.
  function automatic logic [W_S:0] cla_slice(input logic [W_S-1:0] a,
                                             input logic [W_S-1:0] b,
                                             input logic           ci);
    logic [W_S-1:0]  g;
    logic [W_S-1:0]  p;
    logic [NG_S:0]   gc;
    logic [W_S:0]    c;
    logic            gg;
    logic            gp;
    g     = a & b;
    p     = a ^ b;
    gc    = '0;
    c     = '0;
    gc[0] = ci;
    for (int j = 0; j < NG_S; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    c[0] = gc[0];
    for (int i = 1; i < W_S; i++) begin
      if (i % GROUP == 0) c[i] = gc[i/GROUP];
      else                c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    c[W_S] = gc[NG_S];
    return {c[W_S], p ^ c[W_S-1:0]};
  endfunction

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic             adv_s;

  // Subtraction folds into the adder; in_cin is masked so it cannot leak in subtract mode.
  assign b_eff_s   = in_sub ? ~in_b : in_b;
  assign cin_eff_s = in_sub ? 1'b1 : in_cin;
  assign adv_s     = !out_valid || out_ready;
  assign in_ready  = adv_s || !rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * W_S;
    localparam int UW = WIDTH - LO;

    logic [UW-1:0]       a_up_s;
    logic [UW-1:0]       b_up_s;
    logic                cin_s;
    logic                vin_s;
    logic [W_S:0]        res_s;
    logic [LO+W_S-1:0]   sum_s;
    logic [LO+W_S-1:0]   sum_r;
    logic                v_r;
    logic                c_r;

    assign res_s = cla_slice(a_up_s[W_S-1:0], b_up_s[W_S-1:0], cin_s);

    if (k == 0) begin : g_head
      assign a_up_s = in_a;
      assign b_up_s = b_eff_s;
      assign cin_s  = cin_eff_s;
      assign vin_s  = in_valid;
      assign sum_s  = res_s[W_S-1:0];
    end else begin : g_body
      assign a_up_s = g_stage[k-1].g_fwd.a_r;
      assign b_up_s = g_stage[k-1].g_fwd.b_r;
      assign cin_s  = g_stage[k-1].c_r;
      assign vin_s  = g_stage[k-1].v_r;
      assign sum_s  = {res_s[W_S-1:0], g_stage[k-1].sum_r};
    end

    // Stage register: valid, slice carry and resolved low sum bits; frozen during a stall.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (adv_s) begin
        v_r   <= vin_s;
        c_r   <= res_s[W_S];
        sum_r <= sum_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [UW-W_S-1:0] a_r;
      logic [UW-W_S-1:0] b_r;

      // Skew register for the operand bits that later stages still have to add.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv_s) begin
          a_r <= a_up_s[UW-1:W_S];
          b_r <= b_up_s[UW-1:W_S];
        end
      end
    end else begin : g_tail
      logic ovf_r;

      // Signed overflow uses the effective B sign bit, available only in the top slice.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= (a_up_s[W_S-1] == b_up_s[W_S-1]) && (res_s[W_S-1] != a_up_s[W_S-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign out_sum   = g_stage[STAGES-1].sum_r;
  assign out_cout  = g_stage[STAGES-1].c_r;
  assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed cases, throughput, backpressure,
// mid-flight reset on a 16/4/2 instance, then random sweeps on 8/4/1, 32/4/4, 32/8/2.
module tb_cla_pipe_adder;
  localparam int W  = 16;
  localparam int ST = 2;

  typedef struct {
    logic [33:0] r;
    int          e;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, iv, ir, ordy, ov, cin, sub, cout, ovf;
  logic [W-1:0]  a, b, sum;

  logic          sv, scin, ssub;
  logic [31:0]   sa, sb;
  logic          s8_ir, s8_ov, s8_c, s8_o;
  logic [7:0]    s8_sum;
  logic          sa_ir, sa_ov, sa_c, sa_o;
  logic [31:0]   sa_sum;
  logic          sb_ir, sb_ov, sb_c, sb_o;
  logic [31:0]   sb_sum;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
    .in_cin(cin), .in_sub(sub), .out_valid(ov), .out_ready(ordy), .out_sum(sum),
    .out_cout(cout), .out_ovf(ovf));

  cla_pipe_adder #(.WIDTH(8), .GROUP(4), .STAGES(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(s8_ir), .in_a(sa[7:0]), .in_b(sb[7:0]),
    .in_cin(scin), .in_sub(ssub), .out_valid(s8_ov), .out_ready(1'b1), .out_sum(s8_sum),
    .out_cout(s8_c), .out_ovf(s8_o));

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(4)) d32a (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sa_ir), .in_a(sa), .in_b(sb),
    .in_cin(scin), .in_sub(ssub), .out_valid(sa_ov), .out_ready(1'b1), .out_sum(sa_sum),
    .out_cout(sa_c), .out_ovf(sa_o));

  cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(2)) d32b (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sb_ir), .in_a(sa), .in_b(sb),
    .in_cin(scin), .in_sub(ssub), .out_valid(sb_ov), .out_ready(1'b1), .out_sum(sb_sum),
    .out_cout(sb_c), .out_ovf(sb_o));

  ent_t q[$], q8[$], qa[$], qb[$];
  int   checks = 0, errors = 0, edge_n = 0, nres = 0;
  bit   last_acc, last_cons, lat_on;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub, input int w);
    logic [63:0] m, be, full;
    logic [31:0] s;
    logic        co, vf;
    m    = (64'd1 << w) - 64'd1;
    be   = msub ? ((~{32'd0, mb}) & m) : {32'd0, mb};
    full = {32'd0, ma} + be + {63'd0, (msub ? 1'b1 : mcin)};
    s    = full[31:0] & m[31:0];
    co   = full[w];
    vf   = (ma[w-1] == be[w-1]) && (s[w-1] != ma[w-1]);
    return {vf, co, s};
  endfunction

  task automatic step();
    ent_t e;
    @(negedge clk);
    last_cons = (ov && ordy);
    last_acc  = (iv && ir);
    if (last_cons) begin
      nres++;
      if (q.size() == 0) check("sb_extra", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("sb_res", {30'd0, ovf, cout, 16'd0, sum}, {30'd0, e.r});
        if (lat_on) check("sb_lat", edge_n + 1 - e.e, ST);
      end
    end
    if (last_acc) begin
      e.r = model({16'd0, a}, {16'd0, b}, cin, sub, W);
      e.e = edge_n + 1;
      q.push_back(e);
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic rnd_in();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                          input logic dcin, input logic dsub, input logic [17:0] exp);
    a = da; b = db; cin = dcin; sub = dsub; iv = 1'b1;
    step();
    iv = 1'b0;
    check({tag, "_v0"}, ov, 1'b0);
    step();
    check({tag, "_v1"}, ov, 1'b1);
    check(tag, {ovf, cout, sum}, exp);
    step();
  endtask

  task automatic spop(input int idx, output ent_t e, output bit ok);
    ok = 1'b0;
    case (idx)
      0: begin ok = (q8.size() != 0); if (ok) e = q8.pop_front(); end
      1: begin ok = (qa.size() != 0); if (ok) e = qa.pop_front(); end
      default: begin ok = (qb.size() != 0); if (ok) e = qb.pop_front(); end
    endcase
  endtask

  task automatic sstep();
    logic [33:0] got [3];
    logic [2:0]  vld;
    int          stg [3];
    ent_t        e;
    bit          ok;
    stg[0] = 1; stg[1] = 4; stg[2] = 2;
    @(negedge clk);
    got[0] = {s8_o, s8_c, 24'd0, s8_sum};
    got[1] = {sa_o, sa_c, sa_sum};
    got[2] = {sb_o, sb_c, sb_sum};
    vld    = {sb_ov, sa_ov, s8_ov};
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        spop(i, e, ok);
        if (!ok) check($sformatf("sw%0d_extra", i), 64'd1, 64'd0);
        else begin
          check($sformatf("sw%0d_res", i), {30'd0, got[i]}, {30'd0, e.r});
          check($sformatf("sw%0d_lat", i), edge_n + 1 - e.e, stg[i]);
        end
      end
    end
    if (sv) begin
      check("sw_rdy", {s8_ir, sa_ir, sb_ir}, 3'b111);
      e.e = edge_n + 1;
      e.r = model({24'd0, sa[7:0]}, {24'd0, sb[7:0]}, scin, ssub, 8);  q8.push_back(e);
      e.r = model(sa, sb, scin, ssub, 32);                              qa.push_back(e);
      qb.push_back(e);
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  initial begin
    logic [9:0] pat;
    int         n, n0;
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
    sv = 1'b0; sa = 32'd0; sb = 32'd0; scin = 1'b0; ssub = 1'b0; lat_on = 1'b1;
    step();
    step();
    check("rst_valid", ov, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_flags", {cout, ovf}, 2'b00);
    check("rst_ready", ir, 1'b1);
    rst_n = 1'b1;

    directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    directed("add_cross", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
    directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

    // eight back-to-back beats must emerge on eight consecutive cycles
    rnd_in(); iv = 1'b1; pat = 10'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) iv = 1'b0;
      step();
      pat[i] = last_cons;
      if (last_acc) rnd_in();
    end
    check("thru_pat", pat, 10'b1111111100);

    lat_on = 1'b0;
    iv = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (last_acc) rnd_in(); end
    ordy = 1'b0;
    step();
    if (last_acc) rnd_in();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", ir, 1'b0);
      check("bp_valid", ov, 1'b1);
      check("bp_hold", {ovf, cout, 16'd0, sum}, (q.size() != 0) ? q[0].r : 34'h3FFFFFFFF);
    end
    ordy = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (last_acc) rnd_in(); end
    n = 0;
    for (int i = 0; i < 500 && n < 50; i++) begin
      ordy = ~ordy;
      step();
      if (last_acc) begin n++; rnd_in(); end
    end
    check("tog_cnt", n, 50);
    iv = 1'b0; ordy = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 0);
    lat_on = 1'b1;

    // reset with two beats in flight
    rnd_in(); iv = 1'b1; step(); rnd_in(); step();
    iv = 1'b0; ordy = 1'b0; rst_n = 1'b0;
    step();
    check("mrst_valid", ov, 1'b0);
    check("mrst_sum", sum, 16'h0000);
    check("mrst_flags", {cout, ovf}, 2'b00);
    check("mrst_ready", ir, 1'b1);
    q.delete();
    rst_n = 1'b1; ordy = 1'b1; n0 = nres;
    repeat (4) step();
    check("mrst_stale", nres - n0, 0);

    sv = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      sa = $urandom; sb = $urandom; scin = 1'($urandom); ssub = 1'($urandom);
      sstep();
    end
    sv = 1'b0;
    for (int i = 0; i < 8; i++) sstep();
    check("sw_empty", q8.size() + qa.size() + qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
